// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave control path: FSM state
// encoding, keypad/BCD widths and keypad decode functions.
package microwave_pkg;

  localparam int KEY_W = 10;
  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < KEY_W; i++) begin
      n = n + 4'(k[i]);
    end
    return (n == 4'd1);
  endfunction

  function automatic logic [BCD_W-1:0] encode_key(input logic [KEY_W-1:0] k);
    logic [BCD_W-1:0] enc;
    enc = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (k[i]) enc = BCD_W'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/cook_controller_if.sv
// Panel/timer signal bundle between the cook controller and its surroundings.
// Semantics: keypad/start/stop are level inputs; loadn and timer_clrn are
// active-low single-cycle strobes; timer_en is a single-cycle tick; there is
// no backpressure, every strobe is consumed on the edge that sees it.
interface cook_controller_if;
  import microwave_pkg::*;

  logic [KEY_W-1:0] keypad;
  logic             start;
  logic             stop;
  logic             door_closed;
  logic             timer_zero;
  logic [BCD_W-1:0] data;
  logic             loadn;
  logic             timer_clrn;
  logic             timer_en;
  logic             mag_on;
  logic             done;

  modport master (
    output keypad, start, stop, door_closed, timer_zero,
    input  data, loadn, timer_clrn, timer_en, mag_on, done
  );

  modport slave (
    input  keypad, start, stop, door_closed, timer_zero,
    output data, loadn, timer_clrn, timer_en, mag_on, done
  );

endinterface

// File: rtl/sec_prescaler.sv
// Once-per-second tick generator; counts only while run is high and can be
// restarted from zero, freezing its count otherwise.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic clock,
  input  logic clrn,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clrn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/cook_controller.sv
// Microwave control unit: keypad digit loading, start/stop/pause sequencing,
// door interlock, magnetron drive and the per-second timer count enable.
module cook_controller
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic               clock,
  input  logic               clrn,
  cook_controller_if.slave   bus,
  output state_e             state_o
);

  logic [KEY_W-1:0] key_q, key_prev_q;
  logic             start_q, stop_q;
  state_e           state_q, state_d;
  logic [BCD_W-1:0] data_q;
  logic             loadn_q, timer_clrn_q, mag_on_q, done_q;

  logic accept, start_ok, load_d, clear_d;
  logic pre_run, pre_restart, tick;

  // A press counts only on the first one-hot sample after an all-zero sample.
  assign accept   = is_onehot(key_q) && (key_prev_q == '0);
  assign start_ok = start_q && bus.door_closed && !bus.timer_zero;

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    clear_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stop_q) begin
          clear_d = 1'b1;
        end else if (accept) begin
          state_d = ENTRY;
          load_d  = 1'b1;
        end
      end
      ENTRY: begin
        if (stop_q) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (start_ok) begin
          state_d = COOK;
        end else if (accept) begin
          load_d = 1'b1;
        end
      end
      COOK: begin
        if (stop_q || !bus.door_closed) begin
          state_d = PAUSE;
        end else if (bus.timer_zero) begin
          state_d = DONE;
        end
      end
      PAUSE: begin
        if (stop_q) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (start_ok) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (stop_q || !bus.door_closed) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ticks only while COOK persists, so timer_en never lands outside COOK.
  assign pre_restart = (state_d == COOK) && (state_q != COOK);
  assign pre_run     = (state_d == COOK) && (state_q == COOK);

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clock  (clock),
    .clrn   (clrn),
    .run    (pre_run),
    .restart(pre_restart),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (!clrn) begin
      key_q        <= '0;
      key_prev_q   <= '0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      state_q      <= IDLE;
      data_q       <= '0;
      loadn_q      <= 1'b1;
      timer_clrn_q <= 1'b0;
      mag_on_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      key_q        <= bus.keypad;
      key_prev_q   <= key_q;
      start_q      <= bus.start;
      stop_q       <= bus.stop;
      state_q      <= state_d;
      if (load_d) data_q <= encode_key(key_q);
      loadn_q      <= !load_d;
      timer_clrn_q <= !clear_d;
      mag_on_q     <= (state_d == COOK);
      done_q       <= (state_d == DONE);
    end
  end

  assign bus.data       = data_q;
  assign bus.loadn      = loadn_q;
  assign bus.timer_clrn = timer_clrn_q;
  assign bus.timer_en   = tick;
  assign bus.mag_on     = mag_on_q;
  assign bus.done       = done_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_cook_controller.sv
// Directed bench for cook_controller with a small behavioural countdown timer
// that consumes loadn/data/timer_en/timer_clrn and produces timer_zero.
module tb_cook_controller;
  import microwave_pkg::*;

  logic   clock = 1'b0;
  logic   clrn;
  logic   force_zero;
  int     secs = 0;
  int     total = 0;
  int     bad = 0;
  state_e state;

  cook_controller_if bus ();

  cook_controller #(.TICKS_PER_SEC(100)) dut (
    .clock  (clock),
    .clrn   (clrn),
    .bus    (bus),
    .state_o(state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // downstream timer model (seconds only, digits shift in decimally)
  always @(posedge clock) begin
    if (!clrn || !bus.timer_clrn) secs <= 0;
    else if (!bus.loadn) secs <= (secs * 10 + int'(bus.data)) % 1000;
    else if (bus.timer_en && secs != 0) secs <= secs - 1;
  end

  always_comb bus.timer_zero = force_zero || (secs == 0);

  // driver tasks
  task automatic press_key(input int d);
    bus.keypad = KEY_W'(1) << d;
    repeat (2) @(negedge clock);
    bus.keypad = '0;
    repeat (3) @(negedge clock);
  endtask

  task automatic start_cook();
    bus.start = 1'b1;
    @(negedge clock);
    total++;
    if (bus.mag_on !== 1'b0) begin bad++; $display("FAIL start_early_mag: got %0b want 0", bus.mag_on); end
    bus.start = 1'b0;
    @(negedge clock);
    total++;
    if (bus.mag_on !== 1'b1) begin bad++; $display("FAIL start_mag_on: got %0b want 1", bus.mag_on); end
    total++;
    if (state !== COOK) begin bad++; $display("FAIL start_state: got %0d want %0d", state, COOK); end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (bus.timer_clrn !== 1'b0) begin bad++; $display("FAIL reset_timer_clrn: got %0b want 0", bus.timer_clrn); end
    total++; if (bus.loadn !== 1'b1) begin bad++; $display("FAIL reset_loadn: got %0b want 1", bus.loadn); end
    total++; if (bus.mag_on !== 1'b0) begin bad++; $display("FAIL reset_mag_on: got %0b want 0", bus.mag_on); end
    total++; if (bus.timer_en !== 1'b0) begin bad++; $display("FAIL reset_timer_en: got %0b want 0", bus.timer_en); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    total++; if (bus.data !== 4'd0) begin bad++; $display("FAIL reset_data: got %0d want 0", bus.data); end
    clrn = 1'b1;
    @(negedge clock);
    total++; if (bus.timer_clrn !== 1'b1) begin bad++; $display("FAIL release_timer_clrn: got %0b want 1", bus.timer_clrn); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL release_state: got %0d want %0d", state, IDLE); end
  endtask

  task automatic test_keys();
    int pulses = 0;
    int digits[3] = '{1, 3, 0};
    for (int k = 0; k < 3; k++) begin
      bus.keypad = KEY_W'(1) << digits[k];
      for (int c = 1; c <= 7; c++) begin
        @(negedge clock);
        if (bus.loadn === 1'b0) pulses++;
        total++;
        if (bus.loadn !== ((c == 2) ? 1'b0 : 1'b1)) begin
          bad++; $display("FAIL key%0d_loadn_c%0d: got %0b want %0b", digits[k], c, bus.loadn, (c != 2));
        end
        if (c == 2) begin
          total++;
          if (bus.data !== 4'(digits[k])) begin bad++; $display("FAIL key_data: got %0d want %0d", bus.data, digits[k]); end
        end
        if (c == 5) bus.keypad = '0;
      end
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL key_pulse_count: got %0d want 3", pulses); end
    total++; if (state !== ENTRY) begin bad++; $display("FAIL key_state: got %0d want %0d", state, ENTRY); end
  endtask

  task automatic test_stop_entry();
    bus.stop = 1'b1;
    @(negedge clock);
    total++; if (bus.timer_clrn !== 1'b1) begin bad++; $display("FAIL stop_early_clrn: got %0b want 1", bus.timer_clrn); end
    bus.stop = 1'b0;
    @(negedge clock);
    total++; if (bus.timer_clrn !== 1'b0) begin bad++; $display("FAIL stop_clrn: got %0b want 0", bus.timer_clrn); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL stop_state: got %0d want %0d", state, IDLE); end
    @(negedge clock);
    total++; if (bus.timer_clrn !== 1'b1) begin bad++; $display("FAIL stop_clrn_end: got %0b want 1", bus.timer_clrn); end
  endtask

  task automatic test_cook();
    int ticks = 0;
    press_key(5);
    start_cook();
    for (int c = 1; c <= 505; c++) begin
      @(negedge clock);
      if (bus.timer_en === 1'b1) begin
        total++;
        if (c != 100 * (ticks + 1)) begin bad++; $display("FAIL cook_tick_time: got %0d want %0d", c, 100 * (ticks + 1)); end
        ticks++;
      end
      if (c == 501) begin
        total++; if (bus.mag_on !== 1'b1) begin bad++; $display("FAIL cook_mag_before_done: got %0b want 1", bus.mag_on); end
      end
      if (c == 502) begin
        total++; if (bus.mag_on !== 1'b0) begin bad++; $display("FAIL cook_mag_after_done: got %0b want 0", bus.mag_on); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL cook_done: got %0b want 1", bus.done); end
        total++; if (state !== DONE) begin bad++; $display("FAIL cook_state_done: got %0d want %0d", state, DONE); end
      end
    end
    total++; if (ticks != 5) begin bad++; $display("FAIL cook_tick_count: got %0d want 5", ticks); end
    bus.door_closed = 1'b0;
    @(negedge clock);
    total++; if (bus.timer_clrn !== 1'b0) begin bad++; $display("FAIL done_door_clrn: got %0b want 0", bus.timer_clrn); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL done_door_state: got %0d want %0d", state, IDLE); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_door_done: got %0b want 0", bus.done); end
    bus.door_closed = 1'b1;
    @(negedge clock);
    total++; if (bus.timer_clrn !== 1'b1) begin bad++; $display("FAIL done_door_clrn_end: got %0b want 1", bus.timer_clrn); end
  endtask

  task automatic test_pause();
    int ticks = 0;
    press_key(9);
    start_cook();
    for (int c = 1; c <= 460; c++) begin
      @(negedge clock);
      if (bus.timer_en === 1'b1) begin
        total++;
        if (c != 100 * (ticks + 1) || ticks >= 2) begin bad++; $display("FAIL pause_tick_time: got %0d want %0d", c, 100 * (ticks + 1)); end
        ticks++;
      end
      if (c == 250) begin
        total++; if (bus.mag_on !== 1'b1) begin bad++; $display("FAIL pause_mag_before: got %0b want 1", bus.mag_on); end
        bus.door_closed = 1'b0;
      end
      if (c == 251) begin
        total++; if (bus.mag_on !== 1'b0) begin bad++; $display("FAIL pause_mag_off: got %0b want 0", bus.mag_on); end
        total++; if (state !== PAUSE) begin bad++; $display("FAIL pause_state: got %0d want %0d", state, PAUSE); end
      end
    end
    total++; if (ticks != 2) begin bad++; $display("FAIL pause_tick_count: got %0d want 2", ticks); end
    bus.door_closed = 1'b1;
    ticks = 0;
    start_cook();
    for (int c = 1; c <= 130; c++) begin
      @(negedge clock);
      if (bus.timer_en === 1'b1) begin
        total++;
        if (c != 100) begin bad++; $display("FAIL resume_tick_time: got %0d want 100", c); end
        ticks++;
      end
      if (c == 120) bus.door_closed = 1'b0;
      if (c == 121) begin
        total++; if (state !== PAUSE) begin bad++; $display("FAIL resume_pause_state: got %0d want %0d", state, PAUSE); end
      end
    end
    total++; if (ticks != 1) begin bad++; $display("FAIL resume_tick_count: got %0d want 1", ticks); end
    bus.door_closed = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_stop_start_pause();
    int lows = 0;
    int mags = 0;
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    @(negedge clock);
    total++; if (state !== PAUSE) begin bad++; $display("FAIL ss_state_pre: got %0d want %0d", state, PAUSE); end
    if (bus.timer_clrn === 1'b0) lows++;
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clock);
      if (bus.timer_clrn === 1'b0) lows++;
      if (bus.mag_on !== 1'b0) mags++;
      if (c == 2) begin
        total++; if (bus.timer_clrn !== 1'b0) begin bad++; $display("FAIL ss_clrn: got %0b want 0", bus.timer_clrn); end
        total++; if (state !== IDLE) begin bad++; $display("FAIL ss_state: got %0d want %0d", state, IDLE); end
      end
    end
    total++; if (lows != 1) begin bad++; $display("FAIL ss_clrn_pulses: got %0d want 1", lows); end
    total++; if (mags != 0) begin bad++; $display("FAIL ss_mag_cycles: got %0d want 0", mags); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL ss_state_end: got %0d want %0d", state, IDLE); end
  endtask

  task automatic test_multi_key();
    int pulses = 0;
    press_key(4);
    force_zero = 1'b1;
    bus.keypad = (KEY_W'(1) << 2) | (KEY_W'(1) << 7);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (bus.loadn === 1'b0) pulses++;
      total++;
      if (state !== ENTRY) begin bad++; $display("FAIL multi_state_c%0d: got %0d want %0d", c, state, ENTRY); end
      if (c == 1) bus.start = 1'b1;
      if (c == 2) bus.start = 1'b0;
      if (c == 4) bus.keypad = KEY_W'(1) << 2;
      if (c == 6) bus.keypad = '0;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL multi_loadn_pulses: got %0d want 0", pulses); end
    force_zero = 1'b0;
    bus.door_closed = 1'b0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (state !== ENTRY) begin bad++; $display("FAIL door_open_start_state: got %0d want %0d", state, ENTRY); end
    total++; if (bus.mag_on !== 1'b0) begin bad++; $display("FAIL door_open_start_mag: got %0b want 0", bus.mag_on); end
    bus.door_closed = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_cook();
    start_cook();
    repeat (20) @(negedge clock);
    clrn = 1'b0;
    @(negedge clock);
    total++; if (bus.mag_on !== 1'b0) begin bad++; $display("FAIL rst_cook_mag: got %0b want 0", bus.mag_on); end
    total++; if (bus.timer_clrn !== 1'b0) begin bad++; $display("FAIL rst_cook_clrn: got %0b want 0", bus.timer_clrn); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL rst_cook_state: got %0d want %0d", state, IDLE); end
    total++; if (bus.timer_en !== 1'b0) begin bad++; $display("FAIL rst_cook_en: got %0b want 0", bus.timer_en); end
    clrn = 1'b1;
    @(negedge clock);
    total++; if (bus.timer_clrn !== 1'b1) begin bad++; $display("FAIL rst_cook_release: got %0b want 1", bus.timer_clrn); end
  endtask

  initial begin
    clrn            = 1'b0;
    force_zero      = 1'b0;
    bus.keypad      = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.door_closed = 1'b1;
    test_reset();
    test_keys();
    test_stop_entry();
    test_cook();
    test_pause();
    test_stop_start_pause();
    test_multi_key();
    test_reset_mid_cook();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cook_controller.md
# cook_controller

Control unit for the microwave controller, directly upstream of the minutes/seconds countdown timer. It turns keypad presses into the timer's serial digit-load pulses and sequences start, stop, pause and door interlock. It also generates the once-per-second count enable and drives the magnetron. It consumes the timer's `zero` flag to end a cook cycle.

## Interface
- `TICKS_PER_SEC`, default 100: clock cycles per one-second count tick, ≥2. Sim uses 100; synthesis overrides.

- `clock`  in  1  system clock, all logic on rising edge
- `clrn`  in  1  reset, synchronous, active-low
- `keypad`  in  10  digit keys, bit i = digit i, level-sensitive
- `start`  in  1  start button, active-high level
- `stop`  in  1  stop/clear button, active-high level
- `door_closed`  in  1  1 = door closed
- `timer_zero`  in  1  timer reports 0:00
- `data`  out  4  BCD digit to timer `data`
- `loadn`  out  1  timer load strobe, active-low
- `timer_clrn`  out  1  timer clear, active-low
- `timer_en`  out  1  timer count enable, one-cycle tick
- `mag_on`  out  1  magnetron drive
- `done`  out  1  cook cycle finished

## Operation
- States: IDLE, ENTRY, COOK, PAUSE, DONE. All outputs are registered.
- Reset values, held while `clrn`=0:
  - state = IDLE
  - `data` = 0, `loadn` = 1
  - `timer_clrn` = 0, so the timer clears alongside this block
  - `timer_en` = 0, `mag_on` = 0, `done` = 0
- Key acceptance:
  - `keypad` is registered each cycle.
  - A press is accepted when the current sample is exactly one-hot and the previous sample was all-zero.
  - Multi-hot samples, and a held key after its first sample, are ignored.
  - Presses are accepted only in IDLE and ENTRY. An accepted press moves IDLE→ENTRY.
- Digit load: on an accepted press, `data` = encoded digit and `loadn` = 0 for exactly one cycle. `data` then holds until the next accepted press.
- No range check on digits. A fourth digit shifts the oldest out, which is timer behaviour.
- Start:
  - From ENTRY or PAUSE, go to COOK only if `door_closed`=1 and `timer_zero`=0.
  - Otherwise `start` is ignored.
- COOK behaviour:
  - `mag_on` = 1.
  - The prescaler restarts at 0 on entry.
  - `timer_en` pulses high for one cycle every `TICKS_PER_SEC` cycles.
- COOK exits:
  - `door_closed`=0 → PAUSE.
  - `stop` → PAUSE.
  - `timer_zero`=1 → DONE.
  - In each case `mag_on`=0 from the next cycle, and the prescaler freezes.
- Stop outside COOK: in IDLE, ENTRY, PAUSE or DONE, `stop` pulses `timer_clrn`=0 for one cycle and goes to IDLE.
- DONE: `done` = 1. Opening the door also clears as above and goes to IDLE.
- Same-cycle priority: `stop` > door open > `timer_zero` > `start` > key.

## Timing
- Key-to-load latency: a press first sampled on edge n gives `loadn`=0 after edge n+1 and `loadn`=1 after edge n+2.
- Start latency: `start` sampled on edge n gives state COOK and `mag_on`=1 after edge n+1. The first `timer_en` follows `TICKS_PER_SEC` cycles after that.
- `timer_en` is never asserted outside COOK, and never in the same cycle as `loadn`=0 or `timer_clrn`=0.
- `timer_zero` is combinational from the timer. COOK→DONE occurs on the edge after the tick that reaches 0:00.
- Cycles stolen by PAUSE are not counted. On resume from PAUSE the prescaler restarts from 0.
- A synchronous reset mid-COOK drops `mag_on` and clears the timer on that same edge.

## Structure
- Shared package `microwave_pkg` holds:
  - the state enum (IDLE, ENTRY, COOK, PAUSE, DONE);
  - `KEY_W` = 10;
  - `BCD_W` = 4.
- One sub-module, `sec_prescaler`, with:
  - inputs: `clock`, `clrn`, `run`, `restart`;
  - output: `tick`;
  - parameter `TICKS_PER_SEC`;
  - counter width $clog2(`TICKS_PER_SEC`).
- Key edge/one-hot detection and the FSM live in `cook_controller`.

## Test plan
- Reset held 3 cycles:
  - during reset, `timer_clrn`=0, `loadn`=1, `mag_on`=0;
  - after release, `timer_clrn`=1 and state = IDLE.
- Press keys 1, 3, 0, each held 5 cycles with 2 idle cycles between:
  - exactly three one-cycle `loadn` pulses;
  - `data` = 1, 3, 0 respectively during each pulse.
- After entering 0:05 with the door closed, pulse `start`:
  - `mag_on`=1 next cycle;
  - `timer_en` ticks every 100 cycles;
  - after `timer_zero` rises, `mag_on`=0 and `done`=1.
- Open the door 250 cycles into COOK:
  - `mag_on`=0 next cycle and no further ticks;
  - close the door and pulse `start`, and ticking resumes with the prescaler restarted.
- Press `stop` and `start` in the same cycle while in PAUSE: `timer_clrn` pulses low once, the FSM goes to IDLE, and `mag_on` stays 0.
- Hold keys 2 and 7 together, then press `start` with `timer_zero`=1: no `loadn` pulse and no transition to COOK.
